// File: rtl/pcpi_mul_seq.sv
// pcpi_mul_seq: PCPI four-lane packed 8x8 multiply, one shared multiplier stepped across byte lanes.
// Optional build macro PCPI_MUL_SEQ_SKIP_EN: funct3 000 computes only lanes 0 and 1.
module pcpi_mul_seq #(
   parameter logic [6:0] OPCODE = 7'b000_1011,
   parameter logic [6:0] FUNCT7 = 7'b000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  cnt;
   logic [1:0]  cnt_next;
   logic        cooldown;
   logic        cooldown_next;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [2:0]  funct3;
   logic [15:0] p      [4];
   logic [15:0] p_next [4];
   logic [7:0]  lane_a;
   logic [7:0]  lane_b;
   logic [15:0] lane_prod;
   logic        active;
   logic        accept;
   logic        lane_we;
   logic        complete;
   logic        last_lane;
   logic [31:0] result;
   logic        unused_insn_bits;

   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    lane_sel = word[7:0];
         2'd1:    lane_sel = word[15:8];
         2'd2:    lane_sel = word[23:16];
         default: lane_sel = word[31:24];
      endcase
   endfunction

   function automatic logic [31:0] pack_result(input logic [2:0]  f3,
                                               input logic [15:0] p0,
                                               input logic [15:0] p1,
                                               input logic [15:0] p2,
                                               input logic [15:0] p3);
      case (f3)
         3'b000:  pack_result = {p1, p0};
         3'b001:  pack_result = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
         3'b010:  pack_result = {p3[15:8], p2[15:8], p1[15:8], p0[15:8]};
         default: pack_result = 32'h0000_0000;
      endcase
   endfunction

   assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   assign active = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7);

   // Shared multiplier always works on the lane selected by cnt from the latched operands.
   assign lane_a    = lane_sel(op_a, cnt);
   assign lane_b    = lane_sel(op_b, cnt);
   assign lane_prod = {8'd0, lane_a} * {8'd0, lane_b};

`ifdef PCPI_MUL_SEQ_SKIP_EN
   assign last_lane = (funct3 == 3'b000) ? (cnt == 2'd1) : (cnt == 2'd3);
`else
   assign last_lane = (cnt == 2'd3);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         cooldown <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         cooldown <= cooldown_next;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      cooldown_next = 1'b0;
      accept        = 1'b0;
      lane_we       = 1'b0;
      complete      = 1'b0;
      case (state)
         IDLE: begin
            // cooldown masks a valid that the core has not yet dropped after ready
            if (active && !cooldown) begin
               accept   = 1'b1;
               cnt_next = 2'd0;
               if (pcpi_insn[14:12] <= 3'd2) begin
                  state_next = BUSY;
               end else begin
                  state_next = DONE;
               end
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (!pcpi_valid) begin
               state_next = IDLE;
               cnt_next   = 2'd0;
            end else begin
               lane_we  = 1'b1;
               cnt_next = cnt + 2'd1;
               if (last_lane) begin
                  complete      = 1'b1;
                  cooldown_next = 1'b1;
                  state_next    = IDLE;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         DONE: begin
            complete      = 1'b1;
            cooldown_next = 1'b1;
            state_next    = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 2'd0;
         end
      endcase
   end

   // Lane product registers with this cycle's product merged in, so the result sees the last lane.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         if (lane_we && (cnt == 2'(k))) begin
            p_next[k] = lane_prod;
         end else begin
            p_next[k] = p[k];
         end
      end
      result = pack_result(funct3, p_next[0], p_next[1], p_next[2], p_next[3]);
   end

   // Operand latches, lane registers and registered PCPI outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a       <= 32'h0000_0000;
         op_b       <= 32'h0000_0000;
         funct3     <= 3'b000;
         for (int k = 0; k < 4; k++) begin
            p[k] <= 16'h0000;
         end
         pcpi_ready <= 1'b0;
         pcpi_wr    <= 1'b0;
         pcpi_wait  <= 1'b0;
         pcpi_rd    <= 32'h0000_0000;
      end else begin
         if (accept) begin
            op_a   <= pcpi_rs1;
            op_b   <= pcpi_rs2;
            funct3 <= pcpi_insn[14:12];
         end
         for (int k = 0; k < 4; k++) begin
            p[k] <= p_next[k];
         end
         pcpi_ready <= complete;
         pcpi_wr    <= complete;
         pcpi_wait  <= (state_next == BUSY);
         if (complete) begin
            pcpi_rd <= result;
         end
      end
   end

endmodule
